// File: rtl/maze_vga_renderer_if.sv
// rtl/maze_vga_renderer_if.sv - carver-to-renderer and renderer-to-DAC signal bundle
//
// Purpose: groups the carver snapshot inputs and the VGA output pins of the
// maze renderer so they travel as one port.
// Signals:
//   maze_data[255:0]  cell bitmap, bit x+16*y, 1=open, 0=wall
//   maze_done         carver finish flag
//   curr_x, curr_y    carver current cell
//   hsync, vsync      active-low sync pulses
//   rgb[11:0]         {R,G,B} 4 bits each
//   frame_start       one-clk pulse at counter (0,0)
//   snapshot_valid    held snapshot was taken with maze_done=1
// Modports: master = carver/board side, slave = renderer.
interface maze_vga_renderer_if;
  logic [255:0] maze_data;
  logic         maze_done;
  logic [3:0]   curr_x;
  logic [3:0]   curr_y;
  logic         hsync;
  logic         vsync;
  logic [11:0]  rgb;
  logic         frame_start;
  logic         snapshot_valid;

  modport master (
    output maze_data, maze_done, curr_x, curr_y,
    input  hsync, vsync, rgb, frame_start, snapshot_valid
  );

  modport slave (
    input  maze_data, maze_done, curr_x, curr_y,
    output hsync, vsync, rgb, frame_start, snapshot_valid
  );
endinterface

// File: rtl/maze_vga_renderer.sv
// rtl/maze_vga_renderer.sv - 16x16 maze bitmap to VGA raster renderer
//
// Purpose: scans a VGA raster, snapshots the carver state once per frame at
// vertical-blank entry and paints cells, cursor and border into 12-bit RGB.
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high
//   vga    maze_vga_renderer_if.slave (carver inputs, sync/rgb/status outputs)
// Timing parameters default to 640x480@60; they exist so a reduced raster
// can be used where a full frame is impractical.
module maze_vga_renderer #(
  parameter int CLK_DIV  = 4,
  parameter int CELL_PX  = 24,
  parameter int ORIGIN_X = 128,
  parameter int ORIGIN_Y = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic clk,
  input  logic reset,
  maze_vga_renderer_if.slave vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int SUB_W   = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;

  localparam logic [3:0]       DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]       H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0]       V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0]       HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]       HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]       VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]       VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0]       GX0      = 10'(ORIGIN_X);
  localparam logic [9:0]       GX1      = 10'(ORIGIN_X + 16 * CELL_PX);
  localparam logic [9:0]       GY0      = 10'(ORIGIN_Y);
  localparam logic [9:0]       GY1      = 10'(ORIGIN_Y + 16 * CELL_PX);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CELL_PX - 1);

  logic [3:0]       div;
  logic [9:0]       hcount, vcount;
  logic [SUB_W-1:0] sub_x, sub_y;
  logic [3:0]       cell_x, cell_y;

  logic [255:0]     snap_map;
  logic [3:0]       snap_x, snap_y;
  logic             snap_done;

  logic             s1_vis, s1_grid, s1_hs, s1_vs;
  logic [3:0]       s1_cx, s1_cy;
  logic             hsync_q, vsync_q;
  logic [11:0]      rgb_q;

  logic             tick, h_wrap;
  logic [9:0]       h_next, v_next;
  logic [11:0]      pix_rgb;

  assign tick   = (div == DIV_LAST);
  assign h_wrap = (hcount == H_LAST);
  assign h_next = h_wrap ? 10'd0 : hcount + 10'd1;
  assign v_next = h_wrap ? ((vcount == V_LAST) ? 10'd0 : vcount + 10'd1) : vcount;

  // Stage-2 colour: first matching rule wins.
  always_comb begin
    pix_rgb = 12'h000;
    if (!s1_vis)
      pix_rgb = 12'h000;
    else if (!s1_grid)
      pix_rgb = 12'h00F;
    else if (s1_cx == snap_x && s1_cy == snap_y)
      pix_rgb = snap_done ? 12'h0F0 : 12'hF00;
    else if (snap_map[{s1_cy, s1_cx}])
      pix_rgb = 12'hFFF;
    else
      pix_rgb = 12'h000;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div       <= 4'd0;
      hcount    <= 10'd0;
      vcount    <= 10'd0;
      sub_x     <= '0;
      sub_y     <= '0;
      cell_x    <= 4'd0;
      cell_y    <= 4'd0;
      snap_map  <= '0;
      snap_x    <= 4'd0;
      snap_y    <= 4'd0;
      snap_done <= 1'b0;
      s1_vis    <= 1'b0;
      s1_grid   <= 1'b0;
      s1_hs     <= 1'b1;
      s1_vs     <= 1'b1;
      s1_cx     <= 4'd0;
      s1_cy     <= 4'd0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      rgb_q     <= 12'h000;
    end else begin
      div <= tick ? 4'd0 : div + 4'd1;
      if (tick) begin
        hcount <= h_next;
        vcount <= v_next;

        // Cell indices track the counters directly: re-zeroed when the
        // raster enters the grid origin, stepped on every sub-cell wrap.
        // Their values outside the grid are never used.
        if (h_next == GX0) begin
          sub_x  <= '0;
          cell_x <= 4'd0;
        end else if (sub_x == SUB_LAST) begin
          sub_x  <= '0;
          cell_x <= cell_x + 4'd1;
        end else begin
          sub_x  <= sub_x + 1'b1;
        end

        if (h_wrap) begin
          if (v_next == GY0) begin
            sub_y  <= '0;
            cell_y <= 4'd0;
          end else if (sub_y == SUB_LAST) begin
            sub_y  <= '0;
            cell_y <= cell_y + 4'd1;
          end else begin
            sub_y  <= sub_y + 1'b1;
          end
        end

        // Only capture point of carver state: first blanking line.
        if (hcount == 10'd0 && vcount == V_VIS) begin
          snap_map  <= vga.maze_data;
          snap_x    <= vga.curr_x;
          snap_y    <= vga.curr_y;
          snap_done <= vga.maze_done;
        end

        s1_vis  <= (hcount < H_VIS) && (vcount < V_VIS);
        s1_grid <= (hcount >= GX0) && (hcount < GX1) && (vcount >= GY0) && (vcount < GY1);
        s1_cx   <= cell_x;
        s1_cy   <= cell_y;
        s1_hs   <= !((hcount >= HS_START) && (hcount < HS_END));
        s1_vs   <= !((vcount >= VS_START) && (vcount < VS_END));

        hsync_q <= s1_hs;
        vsync_q <= s1_vs;
        rgb_q   <= pix_rgb;
      end
    end
  end

  assign vga.hsync          = hsync_q;
  assign vga.vsync          = vsync_q;
  assign vga.rgb            = rgb_q;
  assign vga.snapshot_valid = snap_done;
  // Counter-aligned, not pipelined: asserts on the tick that leaves (0,0).
  assign vga.frame_start    = tick && !reset && (hcount == 10'd0) && (vcount == 10'd0);

endmodule

// File: tb/tb_maze_vga_renderer.sv
// tb/tb_maze_vga_renderer.sv - scoreboard bench for maze_vga_renderer on a reduced raster
module tb_maze_vga_renderer;

  localparam int D   = 2;
  localparam int CELL = 3;
  localparam int OX  = 4;
  localparam int OY  = 2;
  localparam int HA  = 56;
  localparam int HFP = 4;
  localparam int HS  = 6;
  localparam int HB  = 6;
  localparam int VA  = 52;
  localparam int VFP = 2;
  localparam int VS  = 2;
  localparam int VB  = 3;
  localparam int HT  = HA + HFP + HS + HB;
  localparam int VT  = VA + VFP + VS + VB;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  logic reset = 1'b1;

  maze_vga_renderer_if bus();

  maze_vga_renderer #(
    .CLK_DIV(D), .CELL_PX(CELL), .ORIGIN_X(OX), .ORIGIN_Y(OY),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .vga(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          h;
    int          v;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Reference state: pixel position, divider phase and held snapshot.
  int           mdiv = 0;
  int           mpos = 0;
  int           frames = 0;
  logic [255:0] m_map = '0;
  int           m_cx = 0;
  int           m_cy = 0;
  logic         m_done = 1'b0;
  bit           tick_edge = 0;
  bit           reset_edge = 0;

  function automatic exp_t expect_pixel(int h, int v);
    exp_t e;
    int cx, cy;
    e.h  = h;
    e.v  = v;
    e.hs = !(h >= HA + HFP && h < HA + HFP + HS);
    e.vs = !(v >= VA + VFP && v < VA + VFP + VS);
    if (h >= HA || v >= VA)
      e.rgb = 12'h000;
    else if (h < OX || h >= OX + 16 * CELL || v < OY || v >= OY + 16 * CELL)
      e.rgb = 12'h00F;
    else begin
      cx = (h - OX) / CELL;
      cy = (v - OY) / CELL;
      if (cx == m_cx && cy == m_cy)
        e.rgb = m_done ? 12'h0F0 : 12'hF00;
      else if (m_map[cy * 16 + cx])
        e.rgb = 12'hFFF;
      else
        e.rgb = 12'h000;
    end
    return e;
  endfunction

  // Stimulus-side model: pushes the expected pins for each pixel as the
  // raster leaves it.
  always @(posedge clk) begin
    exp_t e;
    if (reset) begin
      mdiv = 0;
      mpos = 0;
      m_map = '0;
      m_cx = 0;
      m_cy = 0;
      m_done = 1'b0;
      exp_q.delete();
      e.h = -1; e.v = -1; e.hs = 1'b1; e.vs = 1'b1; e.rgb = 12'h000;
      exp_q.push_back(e);
      tick_edge = 0;
      reset_edge = 1;
    end else begin
      reset_edge = 0;
      if (mdiv == D - 1) begin
        exp_q.push_back(expect_pixel(mpos % HT, mpos / HT));
        if (mpos == VA * HT) begin
          m_map  = bus.maze_data;
          m_cx   = int'(bus.curr_x);
          m_cy   = int'(bus.curr_y);
          m_done = bus.maze_done;
        end
        mpos = (mpos + 1) % FRAME;
        if (mpos == 0) frames++;
        mdiv = 0;
        tick_edge = 1;
      end else begin
        mdiv++;
        tick_edge = 0;
      end
    end
  end

  // Monitor: compares pins against the queue after every pixel tick.
  always @(negedge clk) begin
    exp_t e;
    logic fs_exp;
    if (reset) begin
      if (reset_edge) begin
        checks++;
        if (bus.hsync !== 1'b1 || bus.vsync !== 1'b1 || bus.rgb !== 12'h000 ||
            bus.snapshot_valid !== 1'b0 || bus.frame_start !== 1'b0) begin
          errors++;
          $display("FAIL reset_state got hs=%b vs=%b rgb=%h sv=%b fs=%b want hs=1 vs=1 rgb=000 sv=0 fs=0",
                   bus.hsync, bus.vsync, bus.rgb, bus.snapshot_valid, bus.frame_start);
        end
      end
    end else begin
      fs_exp = (mdiv == D - 1) && (mpos == 0);
      checks++;
      if (bus.frame_start !== fs_exp) begin
        errors++;
        $display("FAIL frame_start pos=%0d got %b want %b", mpos, bus.frame_start, fs_exp);
      end
      if (tick_edge) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pixel_queue empty at pos=%0d", mpos);
        end else begin
          e = exp_q.pop_front();
          if (bus.hsync !== e.hs || bus.vsync !== e.vs || bus.rgb !== e.rgb) begin
            errors++;
            $display("FAIL pixel h=%0d v=%0d got hs=%b vs=%b rgb=%h want hs=%b vs=%b rgb=%h",
                     e.h, e.v, bus.hsync, bus.vsync, bus.rgb, e.hs, e.vs, e.rgb);
          end
        end
        checks++;
        if (bus.snapshot_valid !== m_done) begin
          errors++;
          $display("FAIL snapshot_valid pos=%0d got %b want %b", mpos, bus.snapshot_valid, m_done);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_frames(input int n);
    int target;
    bit ok;
    target = frames + n;
    ok = 0;
    for (int i = 0; i < (n * FRAME + 16) * D; i++) begin
      step();
      if (frames >= target) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_frames timeout got frames=%0d want %0d", frames, target);
    end
  endtask

  task automatic wait_line(input int line);
    bit ok;
    ok = 0;
    for (int i = 0; i < (FRAME + 16) * D; i++) begin
      step();
      if (mpos / HT == line) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_line timeout got line=%0d want %0d", mpos / HT, line);
    end
  endtask

  task automatic random_inputs();
    logic [255:0] m;
    for (int i = 0; i < 8; i++) m[i*32 +: 32] = $urandom();
    bus.maze_data = m;
    bus.maze_done = 1'($urandom_range(0, 1));
    bus.curr_x    = 4'($urandom_range(0, 15));
    bus.curr_y    = 4'($urandom_range(0, 15));
  endtask

  initial begin
    bus.maze_data = '0;
    bus.maze_done = 1'b0;
    bus.curr_x    = 4'd0;
    bus.curr_y    = 4'd0;
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;

    // Single open cell (1,1), cursor at origin, not done.
    bus.maze_data = '0;
    bus.maze_data[17] = 1'b1;
    wait_frames(1);

    // Mid-frame change must not disturb the frame being shown.
    wait_line(20);
    random_inputs();
    bus.maze_data[255] = ~bus.maze_data[255];
    bus.maze_done = 1'b1;
    bus.curr_x    = 4'd15;
    bus.curr_y    = 4'd15;
    wait_frames(1);

    // Fully open maze, done dropped.
    wait_line(20);
    bus.maze_data = '1;
    bus.maze_done = 1'b0;
    bus.curr_x    = 4'($urandom_range(0, 15));
    bus.curr_y    = 4'($urandom_range(0, 15));
    wait_frames(1);

    // Reset in the middle of a frame, then fresh random state.
    wait_line(30);
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    random_inputs();
    wait_frames(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
